lenet_input_loader: RTL and testbench
=====================================

# lenet_input_loader

Downstream consumer of the LeNet input buffer (fb3) on the 100 MHz domain. On a start pulse it reads the 28×28 block-accumulated image word by word through fb3's read port. It extracts and scales each accumulated value to an 8-bit pixel and streams the pixels in raster order over a valid/ready interface to the LeNet first layer. It owns fb3 port B (`addrb`, `enb`, `doutb`) exclusively.

## Interface
Parameters:
- `LENET_SIZE`, 28: image side; frame = LENET_SIZE² words (784).
- `ADDR_W`, 10: fb3 address width.
- `ACC_W`, 10: accumulated-value width. The value sits in word bits [15:16-ACC_W]; the low bits are zero.
- `OUT_W`, 8: output pixel width.
- `INVERT`, 1: 1 = output (2^OUT_W−1) − pixel (dark strokes on light paper become MNIST polarity).

Ports:
- `clk` in 1: 100 MHz clock. One clock domain; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to load a frame. Ignored unless IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse after the last pixel is accepted.
- `mem_addr` out ADDR_W: fb3 `addrb`.
- `mem_ren` out 1: fb3 `enb`.
- `mem_rdata` in 16: fb3 `doutb`, valid exactly 1 cycle after `mem_ren`.
- `pix_data` out OUT_W: pixel.
- `pix_valid` out 1: pixel valid.
- `pix_ready` in 1: consumer ready. A beat transfers when valid & ready.
- `pix_last` out 1: high with the final pixel (index 783).
- `pix_sol` out 1: high with the first pixel of each row (column 0).

## Operation
- FSM states:
  - IDLE: waits for `start`, then goes to RUN.
  - RUN: issues reads at addresses 0..LENET_SIZE²−1. Goes to DRAIN after the read of the last address.
  - DRAIN: waits for the `pix_last` beat to be accepted, then goes to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Read issue: `mem_ren`=1 with `mem_addr`=rd_cnt. rd_cnt increments per issued read.
- Flow control is credit based. A read issues only if (fifo_count + inflight − pop_this_cycle) < 2. The FIFO never overflows.
- Returned word: acc = mem_rdata[15 -: ACC_W].
  - pixel = acc[ACC_W-1 -: OUT_W], i.e. a truncating right shift by ACC_W−OUT_W.
  - If INVERT, pixel = 2^OUT_W−1 − pixel.
  - Example: 0xF000 → acc 960 → 240 → inverted 15.
- Output counters: out_col 0..LENET_SIZE−1 and out_row advance per accepted beat.
  - `pix_sol` = (out_col==0).
  - `pix_last` = (out_row==out_col==LENET_SIZE−1).
- `start` outside IDLE: ignored. It has no effect on the counters or the stream.
- `pix_valid` stays high until accepted. `pix_data`, `pix_last` and `pix_sol` are stable while valid & !ready.
- `mem_ren` is 0 in IDLE, DRAIN and DONE.

## Timing
- Reset values: `busy`, `done`, `mem_ren`, `pix_valid`, `pix_last`, `pix_sol` = 0; `mem_addr`, `pix_data` = 0. FSM in IDLE, counters and FIFO cleared.
- `start` sampled high in cycle 0 → RUN and `busy`=1 in cycle 1. First `mem_ren` (addr 0) in cycle 1, data at the RAM output in cycle 2, first `pix_valid` in cycle 3 (registered FIFO output).
- With `pix_ready` held high: one pixel per cycle, no bubbles. Pixel 783 in cycle 786, `done` in cycle 787, `busy`=0 and IDLE in cycle 788.
- Backpressure: at most 2 words are buffered or in flight. Reads resume the cycle after space frees.
- Reset asserted mid-frame: all outputs go to their reset values asynchronously. In-flight RAM data is discarded, and no partial `done` is produced.

## Structure
- The shared package `lenet_pkg` holds:
  - LENET_SIZE and the frame-words constant.
  - ACC_W, derived as $clog2(width-accumulation × height-accumulation) + 4.
  - The `lenet_state_t` enum (IDLE, RUN, DRAIN, DONE).
- One sub-module, `lenet_pix_fifo`: a 2-entry FIFO with registered outputs carrying {pixel, last, sol}, with push/pop/count.
- The extraction/inversion logic is combinational ahead of the FIFO push.

## Test plan
- Reset: hold `rst` with `start`=1 → all outputs 0, no `mem_ren`. Release `rst` → remains IDLE until a fresh `start`.
- Full frame, `pix_ready`=1, RAM word i = i<<6 → 784 beats, addresses 0..783 in order, first `pix_valid` at cycle 3, `pix_sol` on beats 0, 28, 56…, `pix_last` only on beat 783, `done` at cycle 787.
- Conversion with INVERT=1: words 0x0000 / 0xF000 / 0x0040 → pixels 255 / 15 / 255. With INVERT=0 the same words → 0 / 240 / 0.
- Random `pix_ready` (≈50% duty) → no beat lost or duplicated, data stable while stalled, FIFO count never exceeds 2, output order matches addresses.
- `start` pulsed during RUN and DRAIN → ignored; exactly one `done` per accepted start.
- `rst` pulsed at beat 400, then `start` → new frame begins at address 0 and beat 0 with `pix_sol`=1, and 784 beats follow.

Source files
------------

// File: rtl/lenet_input_loader_pkg.sv
// Shared LeNet constants and the input-loader state type.
package lenet_pkg;

   // LeNet input image side and the number of fb3 words in one frame
   localparam int LENET_SIZE        = 28;
   localparam int LENET_FRAME_WORDS = LENET_SIZE * LENET_SIZE;

   // Camera pixels summed into one LeNet pixel (horizontal x vertical)
   localparam int ACC_BLK_W = 8;
   localparam int ACC_BLK_H = 8;

   // Sum of ACC_BLK_W*ACC_BLK_H 4-bit camera pixels
   localparam int ACC_W = $clog2(ACC_BLK_W * ACC_BLK_H) + 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } lenet_state_t;

endpackage

// File: rtl/lenet_input_loader_if.sv
// Pixel stream from the input loader to the LeNet first layer.
interface lenet_input_loader_if #(
   parameter int OUT_W = 8
);
   logic [OUT_W-1:0] pix_data;
   logic             pix_valid;
   logic             pix_ready;
   logic             pix_last;
   logic             pix_sol;

   modport master (
      output pix_data, pix_valid, pix_last, pix_sol,
      input  pix_ready
   );

   modport slave (
      input  pix_data, pix_valid, pix_last, pix_sol,
      output pix_ready
   );
endinterface

// File: rtl/lenet_input_loader_pix_fifo.sv
// Two-entry FIFO; the head entry register drives the outputs directly.
module lenet_pix_fifo #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         valid,
   output logic [1:0]   count
);
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic [1:0]   count_q, count_d;
   logic         do_pop;

   assign do_pop = pop && (count_q != 2'd0);

   // Next-state for the two entries and the occupancy count
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push, do_pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d  = din;
               count_d = 2'd1;
            end else if (count_q == 2'd1) begin
               tail_d  = din;
               count_d = 2'd2;
            end
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Occupancy unchanged; new word lands behind whatever remains
            if (count_q == 2'd1) begin
               head_d = din;
            end else begin
               head_d = tail_q;
               tail_d = din;
            end
         end
         default: ;
      endcase
   end

   // Entry and count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign dout  = head_q;
   assign valid = (count_q != 2'd0);
   assign count = count_q;

endmodule

// File: rtl/lenet_input_loader.sv
// Reads the 28x28 accumulated image out of fb3 port B and streams 8-bit
// pixels in raster order to the LeNet first layer.
module lenet_input_loader #(
   parameter int LENET_SIZE = lenet_pkg::LENET_SIZE,
   parameter int ADDR_W     = 10,
   parameter int ACC_W      = lenet_pkg::ACC_W,
   parameter int OUT_W      = 8,
   parameter int INVERT     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ren,
   input  logic [15:0]       mem_rdata,
   lenet_input_loader_if.master pix
);
   import lenet_pkg::*;

   localparam int FRAME = LENET_SIZE * LENET_SIZE;
   localparam int POS_W = $clog2(LENET_SIZE);
   localparam int FW    = OUT_W + 2;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
   localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(LENET_SIZE - 1);
   localparam logic [OUT_W-1:0]  PIX_MAX   = {OUT_W{1'b1}};

   lenet_state_t      state_q;
   logic [ADDR_W-1:0] rd_cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              rvalid_q;
   logic [POS_W-1:0]  col_q;
   logic [POS_W-1:0]  row_q;

   logic [ACC_W-1:0]  acc;
   logic [OUT_W-1:0]  pix_raw;
   logic [OUT_W-1:0]  pix_conv;
   logic [FW-1:0]     fifo_din;
   logic [FW-1:0]     fifo_dout;
   logic              fifo_valid;
   logic [1:0]        fifo_count;
   logic              pop;
   logic              issue;
   logic              start_acc;
   logic [2:0]        credit;
   logic              unused_lsbs;

   assign pop       = fifo_valid && pix.pix_ready;
   assign start_acc = (state_q == IDLE) && start;

   // Words held in the FIFO plus the one returning from RAM this cycle,
   // minus the one leaving. Reads are combinational so a freed slot is
   // refilled without a bubble.
   assign credit = {1'b0, fifo_count} + {2'b00, rvalid_q} - {2'b00, pop};
   assign issue  = (state_q == RUN) && (credit < 3'd2);

   // Extract the accumulated value, scale to OUT_W and tag the beat
   always_comb begin
      acc      = mem_rdata[15 -: ACC_W];
      pix_raw  = acc[ACC_W-1 -: OUT_W];
      pix_conv = (INVERT != 0) ? (PIX_MAX - pix_raw) : pix_raw;
      fifo_din = {pix_conv,
                  (row_q == LAST_POS) && (col_q == LAST_POS),
                  (col_q == '0)};
   end

   assign unused_lsbs = ^{mem_rdata[15-ACC_W:0], acc[ACC_W-OUT_W-1:0]};

   // Frame sequencing: read issue, drain of the last beat, done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rd_cnt_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q  <= RUN;
                  busy_q   <= 1'b1;
                  rd_cnt_q <= '0;
               end
            end
            RUN: begin
               if (issue) begin
                  rd_cnt_q <= rd_cnt_q + 1'b1;
                  if (rd_cnt_q == LAST_ADDR) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && fifo_dout[1]) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q  <= IDLE;
               busy_q   <= 1'b0;
               rd_cnt_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // RAM return tracking and raster position of the next word pushed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
      end else begin
         rvalid_q <= issue;
         if (start_acc) begin
            col_q <= '0;
            row_q <= '0;
         end else if (rvalid_q) begin
            if (col_q == LAST_POS) begin
               col_q <= '0;
               row_q <= row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
      end
   end

   lenet_pix_fifo #(
      .W (FW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rvalid_q),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .valid (fifo_valid),
      .count (fifo_count)
   );

   assign busy          = busy_q;
   assign done          = done_q;
   assign mem_addr      = rd_cnt_q;
   assign mem_ren       = issue;
   assign pix.pix_valid = fifo_valid;
   assign pix.pix_data  = fifo_dout[FW-1 -: OUT_W];
   assign pix.pix_last  = fifo_dout[1];
   assign pix.pix_sol   = fifo_dout[0];

endmodule

// File: tb/tb_lenet_input_loader.sv
// Bench for lenet_input_loader: two instances (inverting and plain) run in
// lock-step from the same fb3 image, checked against a frame-level model.
module tb_lenet_input_loader;
   localparam int N     = 28;
   localparam int FRAME = N * N;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ready;
   logic        busy1, done1, ren1;
   logic        busy0, done0, ren0;
   logic [9:0]  addr1, addr0;
   logic [15:0] rdata1, rdata0;
   logic [15:0] ram [FRAME];

   lenet_input_loader_if #(.OUT_W(8)) pix1 ();
   lenet_input_loader_if #(.OUT_W(8)) pix0 ();

   assign pix1.pix_ready = ready;
   assign pix0.pix_ready = ready;

   lenet_input_loader #(
      .LENET_SIZE(N), .ADDR_W(10), .ACC_W(10), .OUT_W(8), .INVERT(1)
   ) dut1 (
      .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
      .mem_addr(addr1), .mem_ren(ren1), .mem_rdata(rdata1), .pix(pix1)
   );

   lenet_input_loader #(
      .LENET_SIZE(N), .ADDR_W(10), .ACC_W(10), .OUT_W(8), .INVERT(0)
   ) dut0 (
      .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
      .mem_addr(addr0), .mem_ren(ren0), .mem_rdata(rdata0), .pix(pix0)
   );

   always #5 clk = ~clk;

   // fb3 port B: one-cycle registered read
   always @(posedge clk) begin
      if (ren1) rdata1 <= ram[addr1];
      if (ren0) rdata0 <= ram[addr0];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int issued = 0;
   int beats = 0;
   int beats0 = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int fv = -1;
   int last_fv = -1;
   logic [7:0] got1 [FRAME];
   logic [7:0] got0 [FRAME];
   logic       hold_q = 1'b0;
   logic [7:0] hold_data = 8'd0;
   logic       hold_last = 1'b0;
   logic       hold_sol = 1'b0;

   // Pixel from a 16-bit fb3 word: top 10 bits are the sum, keep its top 8
   function automatic int model_pix(input logic [15:0] w, input bit inv);
      int a;
      int p;
      a = int'(w) >> 6;
      p = a >> 2;
      if (inv) p = 255 - p;
      return p;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the frame model
   always @(negedge clk) begin
      if (rst) begin
         issued = 0;
         beats  = 0;
         beats0 = 0;
         fv     = -1;
         hold_q = 1'b0;
      end else begin
         if (ren1) begin
            check("rd_addr", int'(addr1), issued);
            check("rd_in_frame", int'(issued < FRAME), 1);
            issued++;
         end
         if (pix1.pix_valid && fv < 0) fv = cyc;
         if (hold_q) begin
            check("stall_valid", int'(pix1.pix_valid), 1);
            check("stall_data", int'(pix1.pix_data), int'(hold_data));
            check("stall_last", int'(pix1.pix_last), int'(hold_last));
            check("stall_sol", int'(pix1.pix_sol), int'(hold_sol));
         end
         if (pix1.pix_valid && ready) begin
            if (beats >= FRAME) begin
               check("extra_beat", beats, FRAME - 1);
            end else begin
               check("pix_data", int'(pix1.pix_data), model_pix(ram[beats], 1'b1));
               check("pix_sol", int'(pix1.pix_sol), int'(beats % N == 0));
               check("pix_last", int'(pix1.pix_last), int'(beats == FRAME - 1));
               got1[beats] = pix1.pix_data;
            end
            beats++;
         end
         if (pix0.pix_valid && ready) begin
            if (beats0 < FRAME) begin
               check("pix_data_noinv", int'(pix0.pix_data), model_pix(ram[beats0], 1'b0));
               got0[beats0] = pix0.pix_data;
            end
            beats0++;
         end
         check("inflight_le2", int'(issued - beats <= 2), 1);
         hold_q    = pix1.pix_valid && !ready;
         hold_data = pix1.pix_data;
         hold_last = pix1.pix_last;
         hold_sol  = pix1.pix_sol;
         if (done1) begin
            check("done_at_last", beats, FRAME);
            check("done_lockstep", int'(done0), 1);
            done_cnt++;
            done_cyc = cyc;
            last_fv  = fv;
            issued   = 0;
            beats    = 0;
            beats0   = 0;
            fv       = -1;
         end
      end
   end

   task automatic pulse_start(output int c0);
      @(posedge clk);
      #1 start = 1'b1;
      c0 = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Wait for one done; optionally random ready and stray start pulses
   task automatic wait_done(input int budget, input bit rnd, input bit poke);
      int  d0;
      bit  poked;
      d0    = done_cnt;
      poked = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1 start = 1'b0;
         if (done_cnt != d0) return;
         if (rnd) ready = 1'($urandom_range(0, 1));
         if (poke && i == 50) start = 1'b1;
         if (poke && !poked && issued == FRAME) begin
            start = 1'b1;
            poked = 1'b1;
         end
      end
      check("done_timeout", 0, 1);
   endtask

   initial begin
      int c0;
      int d0;
      bit hit;
      rst   = 1'b1;
      start = 1'b1;
      ready = 1'b1;
      for (int i = 0; i < FRAME; i++) ram[i] = 16'(i << 6);

      // Reset held with start high
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy1), 0);
      check("rst_done", int'(done1), 0);
      check("rst_ren", int'(ren1), 0);
      check("rst_addr", int'(addr1), 0);
      check("rst_valid", int'(pix1.pix_valid), 0);
      check("rst_data", int'(pix1.pix_data), 0);
      check("rst_last", int'(pix1.pix_last), 0);
      check("rst_sol", int'(pix1.pix_sol), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_busy", int'(busy1), 0);
      check("idle_ren", int'(ren1), 0);
      check("idle_valid", int'(pix1.pix_valid), 0);

      // Full frame, ready held high
      pulse_start(c0);
      @(negedge clk);
      check("c1_busy", int'(busy1), 1);
      check("c1_ren", int'(ren1), 1);
      check("c1_addr", int'(addr1), 0);
      wait_done(2000, 1'b0, 1'b0);
      check("busy_after_done", int'(busy1), 0);
      check("first_valid_cycle", last_fv - c0, 3);
      check("done_cycle", done_cyc - c0, 787);
      check("lit_pix0", int'(got1[0]), 255);
      check("lit_pix100", int'(got1[100]), 230);
      check("lit_pix783", int'(got1[783]), 60);
      check("lit_noinv100", int'(got0[100]), 25);
      check("lit_noinv783", int'(got0[783]), 195);

      // Conversion of specific words, both polarities
      ram[0] = 16'h0000;
      ram[1] = 16'hF000;
      ram[2] = 16'h0040;
      pulse_start(c0);
      wait_done(2000, 1'b0, 1'b0);
      check("conv_inv_0000", int'(got1[0]), 255);
      check("conv_inv_F000", int'(got1[1]), 15);
      check("conv_inv_0040", int'(got1[2]), 255);
      check("conv_raw_0000", int'(got0[0]), 0);
      check("conv_raw_F000", int'(got0[1]), 240);
      check("conv_raw_0040", int'(got0[2]), 0);
      for (int i = 0; i < 3; i++) ram[i] = 16'(i << 6);

      // Random backpressure with start pulsed during RUN and DRAIN
      d0 = done_cnt;
      pulse_start(c0);
      wait_done(6000, 1'b1, 1'b1);
      ready = 1'b1;
      repeat (10) @(negedge clk);
      check("one_done_per_start", done_cnt - d0, 1);
      check("idle_after_rand", int'(busy1), 0);

      // Reset in the middle of a frame
      pulse_start(c0);
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if (beats >= 400) begin
            hit = 1'b1;
            break;
         end
      end
      check("reach_beat400", int'(hit), 1);
      d0 = done_cnt;
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", int'(busy1), 0);
      check("midrst_ren", int'(ren1), 0);
      check("midrst_addr", int'(addr1), 0);
      check("midrst_valid", int'(pix1.pix_valid), 0);
      check("midrst_data", int'(pix1.pix_data), 0);
      check("midrst_sol", int'(pix1.pix_sol), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_no_done", done_cnt - d0, 0);
      check("midrst_idle", int'(busy1), 0);
      pulse_start(c0);
      @(negedge clk);
      check("restart_ren", int'(ren1), 1);
      check("restart_addr", int'(addr1), 0);
      wait_done(2000, 1'b0, 1'b0);
      check("restart_first_valid", last_fv - c0, 3);
      check("restart_done_cycle", done_cyc - c0, 787);
      check("restart_one_done", done_cnt - d0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
